// File: rtl/video_ram_address_flip_gen_pkg.sv
// Shared defaults and types for the video DRAM address generator.
// Imported by the row counter, the interface users and the top level.
package video_addr_pkg;

    localparam int ROW_W_DEF = 8;
    localparam int COL_W_DEF = 6;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } row_dir_t;

endpackage

// File: rtl/video_ram_address_flip_gen_if.sv
// Bus bundle between the video timing chain and the address generator.
// master: drives AV/DB/strobes/FLIP_REQ/FRAME; slave: drives AVX/ROW/WRAP/FLIP_ACT.
interface video_ram_address_flip_gen_if #(
    parameter int NUM_PLANES = 2,
    parameter int ROW_W      = 8,
    parameter int ADDR_W     = 14
);

    logic [ADDR_W-1:0]            AV;
    logic [ROW_W-1:0]             DB;
    logic [NUM_PLANES-1:0]        VPOS_WE;
    logic [NUM_PLANES-1:0]        LOAD;
    logic [NUM_PLANES-1:0]        STEP;
    logic [NUM_PLANES-1:0]        DIR;
    logic [NUM_PLANES-1:0]        FLIP_REQ;
    logic                         FRAME;
    logic [NUM_PLANES*ADDR_W-1:0] AVX;
    logic [NUM_PLANES*ROW_W-1:0]  ROW;
    logic [NUM_PLANES-1:0]        WRAP;
    logic [NUM_PLANES-1:0]        FLIP_ACT;

    modport master (
        output AV, DB, VPOS_WE, LOAD, STEP, DIR, FLIP_REQ, FRAME,
        input  AVX, ROW, WRAP, FLIP_ACT
    );

    modport slave (
        input  AV, DB, VPOS_WE, LOAD, STEP, DIR, FLIP_REQ, FRAME,
        output AVX, ROW, WRAP, FLIP_ACT
    );

endinterface

// File: rtl/video_ram_address_flip_gen_row_counter.sv
// Per-plane vertical scroll: vpos register, loadable up/down row counter, wrap pulse.
// Ports: clk/rst, db/vpos_we (vpos write), load/step/dir (counter), row/wrap (state out).
module video_row_scroll_counter
    import video_addr_pkg::*;
#(
    parameter int ROW_W = ROW_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ROW_W-1:0] db,
    input  logic             vpos_we,
    input  logic             load,
    input  logic             step,
    input  logic             dir,
    output logic [ROW_W-1:0] row,
    output logic             wrap
);

    logic [ROW_W-1:0] vpos_q, vpos_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             wrap_q, wrap_d;

    // LOAD reads vpos_q, so a same-cycle vpos write lands one cycle later.
    always_comb begin
        vpos_d = vpos_we ? db : vpos_q;
        row_d  = row_q;
        wrap_d = 1'b0;
        if (load) begin
            row_d = vpos_q;
        end else if (step) begin
            if (row_dir_t'(dir) == DIR_UP) begin
                row_d  = row_q + ROW_W'(1);
                wrap_d = &row_q;
            end else begin
                row_d  = row_q - ROW_W'(1);
                wrap_d = ~|row_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vpos_q <= '0;
            row_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            vpos_q <= vpos_d;
            row_q  <= row_d;
            wrap_q <= wrap_d;
        end
    end

    assign row  = row_q;
    assign wrap = wrap_q;

endmodule

// File: rtl/video_ram_address_flip_gen.sv
// Video DRAM address generator: per-plane scroll counters, frame-committed flip, registered AVX.
// Ports: CLK, RST (async, active-high), bus (slave side of the address-generator interface).
module video_ram_address_flip_gen
    import video_addr_pkg::*;
#(
    parameter int                    NUM_PLANES  = 2,
    parameter int                    ROW_W       = ROW_W_DEF,
    parameter int                    COL_W       = COL_W_DEF,
    parameter int                    ADDR_W      = ROW_W + COL_W,
    parameter logic [NUM_PLANES-1:0] SCROLL_MASK = 'b01
) (
    input  logic                          CLK,
    input  logic                          RST,
    video_ram_address_flip_gen_if.slave   bus
);

    logic [NUM_PLANES*ROW_W-1:0]  row_w;
    logic [NUM_PLANES-1:0]        wrap_w;
    logic [NUM_PLANES-1:0]        flip_act_q, flip_act_d;
    logic [NUM_PLANES*ADDR_W-1:0] avx_q, avx_d;

    for (genvar p = 0; p < NUM_PLANES; p++) begin : g_plane
        if (SCROLL_MASK[p]) begin : g_scroll
            video_row_scroll_counter #(
                .ROW_W (ROW_W)
            ) u_cnt (
                .clk     (CLK),
                .rst     (RST),
                .db      (bus.DB),
                .vpos_we (bus.VPOS_WE[p]),
                .load    (bus.LOAD[p]),
                .step    (bus.STEP[p]),
                .dir     (bus.DIR[p]),
                .row     (row_w[p*ROW_W +: ROW_W]),
                .wrap    (wrap_w[p])
            );
        end else begin : g_direct
            assign row_w[p*ROW_W +: ROW_W] = '0;
            assign wrap_w[p]               = 1'b0;
        end
    end

    // Flip changes only on FRAME so a mid-frame request cannot tear the picture.
    always_comb begin
        flip_act_d = bus.FRAME ? bus.FLIP_REQ : flip_act_q;
    end

    // Uses pre-update row and flip so AVX trails them by exactly one edge.
    always_comb begin
        avx_d = '0;
        for (int p = 0; p < NUM_PLANES; p++) begin
            if (SCROLL_MASK[p]) begin
                avx_d[p*ADDR_W +: ADDR_W] = {
                    row_w[p*ROW_W +: ROW_W],
                    bus.AV[COL_W-1:0] ^ {COL_W{flip_act_q[p]}}
                };
            end else begin
                avx_d[p*ADDR_W +: ADDR_W] = bus.AV ^ {ADDR_W{flip_act_q[p]}};
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            flip_act_q <= '0;
            avx_q      <= '0;
        end else begin
            flip_act_q <= flip_act_d;
            avx_q      <= avx_d;
        end
    end

    assign bus.AVX      = avx_q;
    assign bus.ROW      = row_w;
    assign bus.WRAP     = wrap_w;
    assign bus.FLIP_ACT = flip_act_q;

endmodule

// File: tb/tb_video_ram_address_flip_gen.sv
// Directed bench for video_ram_address_flip_gen: 2-plane default and 3-plane mask 101.
// Expected values are hand-computed constants.
module tb_video_ram_address_flip_gen;

    logic CLK;
    logic RST;
    int   checks;
    int   errors;

    video_ram_address_flip_gen_if #(.NUM_PLANES(2), .ROW_W(8), .ADDR_W(14)) ifa ();
    video_ram_address_flip_gen_if #(.NUM_PLANES(3), .ROW_W(8), .ADDR_W(14)) ifb ();

    video_ram_address_flip_gen #(
        .NUM_PLANES (2),
        .ROW_W      (8),
        .COL_W      (6),
        .ADDR_W     (14),
        .SCROLL_MASK(2'b01)
    ) dut_a (
        .CLK (CLK),
        .RST (RST),
        .bus (ifa.slave)
    );

    video_ram_address_flip_gen #(
        .NUM_PLANES (3),
        .ROW_W      (8),
        .COL_W      (6),
        .ADDR_W     (14),
        .SCROLL_MASK(3'b101)
    ) dut_b (
        .CLK (CLK),
        .RST (RST),
        .bus (ifb.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_a();
        ifa.VPOS_WE = '0;
        ifa.LOAD    = '0;
        ifa.STEP    = '0;
        ifa.DIR     = '0;
        ifa.FRAME   = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        RST = 1'b1;
        ifa.AV = '0; ifa.DB = '0; ifa.FLIP_REQ = '0;
        idle_a();
        ifb.AV = '0; ifb.DB = '0; ifb.VPOS_WE = '0; ifb.LOAD = '0;
        ifb.STEP = '0; ifb.DIR = '0; ifb.FLIP_REQ = '0; ifb.FRAME = 1'b0;
        tick();
        tick();
        check("rst_avx", 64'(ifa.AVX), 64'h0);
        check("rst_row", 64'(ifa.ROW), 64'h0);

        // release reset, first update on next edge
        RST = 1'b0;
        ifa.AV = 14'h0025;
        tick();
        check("rel_avx", 64'(ifa.AVX), {36'h0, 14'h0025, 14'h0025});

        // load 0xFE then count up through the wrap
        ifa.DB = 8'hFE; ifa.VPOS_WE = 2'b01;
        tick();
        ifa.VPOS_WE = 2'b00; ifa.LOAD = 2'b01;
        tick();
        check("up_load_row", 64'(ifa.ROW[7:0]), 64'hFE);
        check("up_load_wrap", 64'(ifa.WRAP), 64'h0);
        ifa.LOAD = 2'b00; ifa.STEP = 2'b01; ifa.DIR = 2'b00;
        tick();
        check("up1_row", 64'(ifa.ROW[7:0]), 64'hFF);
        check("up1_wrap", 64'(ifa.WRAP), 64'h0);
        tick();
        check("up2_row", 64'(ifa.ROW[7:0]), 64'h00);
        check("up2_wrap", 64'(ifa.WRAP), 64'h1);
        tick();
        check("up3_row", 64'(ifa.ROW[7:0]), 64'h01);
        check("up3_wrap", 64'(ifa.WRAP), 64'h0);
        idle_a();

        // load 0x00 then count down through the wrap
        ifa.DB = 8'h00; ifa.VPOS_WE = 2'b01;
        tick();
        ifa.VPOS_WE = 2'b00; ifa.LOAD = 2'b01;
        tick();
        check("dn_load_row", 64'(ifa.ROW[7:0]), 64'h00);
        ifa.LOAD = 2'b00; ifa.STEP = 2'b01; ifa.DIR = 2'b01;
        tick();
        check("dn1_row", 64'(ifa.ROW[7:0]), 64'hFF);
        check("dn1_wrap", 64'(ifa.WRAP), 64'h1);
        tick();
        check("dn2_row", 64'(ifa.ROW[7:0]), 64'hFE);
        check("dn2_wrap", 64'(ifa.WRAP), 64'h0);
        idle_a();

        // load at all-ones with an up-step: LOAD wins, no wrap
        ifa.DB = 8'h55; ifa.VPOS_WE = 2'b01;
        tick();
        ifa.VPOS_WE = 2'b00; ifa.STEP = 2'b01; ifa.DIR = 2'b00;
        tick();
        check("ff_row", 64'(ifa.ROW[7:0]), 64'hFF);
        ifa.LOAD = 2'b01;
        tick();
        check("ldwrap_row", 64'(ifa.ROW[7:0]), 64'h55);
        check("ldwrap_wrap", 64'(ifa.WRAP), 64'h0);
        idle_a();

        // flip commit
        ifa.DB = 8'h12; ifa.VPOS_WE = 2'b01;
        tick();
        ifa.VPOS_WE = 2'b00; ifa.LOAD = 2'b01;
        tick();
        ifa.LOAD = 2'b00; ifa.AV = 14'h0005;
        tick();
        check("pre_flip_avx", 64'(ifa.AVX), {36'h0, 14'h0005, 14'h0485});
        ifa.FLIP_REQ = 2'b11;
        tick();
        check("noframe_act", 64'(ifa.FLIP_ACT), 64'h0);
        check("noframe_avx", 64'(ifa.AVX), {36'h0, 14'h0005, 14'h0485});
        ifa.FRAME = 1'b1;
        tick();
        check("frame_act", 64'(ifa.FLIP_ACT), 64'h3);
        check("frame_avx_lag", 64'(ifa.AVX), {36'h0, 14'h0005, 14'h0485});
        ifa.FRAME = 1'b0;
        tick();
        check("flip_avx", 64'(ifa.AVX), {36'h0, 14'h3FFA, 14'h04BA});
        ifa.FLIP_REQ = 2'b00;
        tick();
        check("req_midframe", 64'(ifa.FLIP_ACT), 64'h3);

        // priority: vpos=0x10, then LOAD+STEP+VPOS_WE with DB=0x20
        ifa.DB = 8'h10; ifa.VPOS_WE = 2'b01;
        tick();
        ifa.DB = 8'h20; ifa.LOAD = 2'b01; ifa.STEP = 2'b01; ifa.DIR = 2'b01;
        tick();
        check("prio_row", 64'(ifa.ROW[7:0]), 64'h10);
        check("prio_wrap", 64'(ifa.WRAP), 64'h0);
        ifa.VPOS_WE = 2'b00; ifa.STEP = 2'b00;
        tick();
        check("prio_load2", 64'(ifa.ROW[7:0]), 64'h20);
        idle_a();

        // asynchronous reset mid-stream with row=0x37 and flip active
        ifa.DB = 8'h37; ifa.VPOS_WE = 2'b01;
        tick();
        ifa.VPOS_WE = 2'b00; ifa.LOAD = 2'b01;
        tick();
        ifa.LOAD = 2'b00; ifa.STEP = 2'b01; ifa.DIR = 2'b00;
        ifa.FLIP_REQ = 2'b00;
        tick();
        ifa.STEP = 2'b00;
        check("mid_row", 64'(ifa.ROW[7:0]), 64'h38);
        check("mid_act", 64'(ifa.FLIP_ACT), 64'h3);
        #2;
        RST = 1'b1;
        #1;
        check("async_avx", 64'(ifa.AVX), 64'h0);
        check("async_row", 64'(ifa.ROW), 64'h0);
        check("async_wrap", 64'(ifa.WRAP), 64'h0);
        check("async_act", 64'(ifa.FLIP_ACT), 64'h0);
        tick();
        RST = 1'b0;
        ifa.AV = 14'h0025;
        tick();
        check("rel2_avx", 64'(ifa.AVX), {36'h0, 14'h0025, 14'h0025});
        check("rel2_act", 64'(ifa.FLIP_ACT), 64'h0);

        // three planes, mask 101
        ifb.DB = 8'h40; ifb.VPOS_WE = 3'b111;
        tick();
        ifb.VPOS_WE = 3'b000; ifb.LOAD = 3'b111;
        tick();
        check("b_load_row", 64'(ifb.ROW), {40'h0, 8'h40, 8'h00, 8'h40});
        ifb.LOAD = 3'b000; ifb.STEP = 3'b111; ifb.DIR = 3'b100;
        ifb.AV = 14'h1234;
        tick();
        check("b_step_row", 64'(ifb.ROW), {40'h0, 8'h3F, 8'h00, 8'h41});
        check("b_avx1", 64'(ifb.AVX), {22'h0, 14'h1034, 14'h1234, 14'h1034});
        ifb.STEP = 3'b000;
        ifb.AV = 14'h0ABC;
        tick();
        check("b_avx2", 64'(ifb.AVX), {22'h0, 14'h0FFC, 14'h0ABC, 14'h107C});
        check("b_wrap", 64'(ifb.WRAP), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
